// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and the MMIO address decoder for dmem_responder.
//   CYCLE_ADDR / TXDATA_ADDR / STATUS_ADDR : MMIO register byte addresses
//   ST_*                                   : STATUS register bit positions
//   MMIO_SEL_BIT                           : address bit choosing MMIO over RAM
package dmem_pkg;

  localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0000;
  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0004;
  localparam logic [31:0] STATUS_ADDR = 32'h8000_0008;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_CNT_LSB   = 8;
  localparam int unsigned MMIO_SEL_BIT = 31;

  typedef enum logic [1:0] {
    MMIO_CYCLE,
    MMIO_TXDATA,
    MMIO_STATUS,
    MMIO_NONE
  } mmio_reg_e;

  // Takes the word address (byte address bits [31:2]) so byte offsets never matter.
  function automatic mmio_reg_e mmio_decode(input logic [29:0] word_addr);
    if (word_addr == CYCLE_ADDR[31:2])  return MMIO_CYCLE;
    if (word_addr == TXDATA_ADDR[31:2]) return MMIO_TXDATA;
    if (word_addr == STATUS_ADDR[31:2]) return MMIO_STATUS;
    return MMIO_NONE;
  endfunction

endpackage

// File: rtl/dmem_responder_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, reset (async, active-low)
//   push/wdata : enqueue request; accepted when not full or when popping this cycle
//   pop        : dequeue head (ignored while empty)
//   rdata      : head entry, 0 while empty
//   empty/full/count : occupancy
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == (PW+1)'(DEPTH));
  assign count = r_count;
  assign rdata = empty ? '0 : r_mem[r_rd_ptr];

  // A pop frees the head slot within the same edge, so a full FIFO still takes a push.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-port responder for the MIPS core (word RAM + MMIO).
// Optional transmit FIFO built when DMEM_TXFIFO_EN is defined.
//   clk, reset (async, active-low)
//   memwrite/aluout/writedata : core store strobe, byte address, store data
//   readdata                  : combinational load data
//   tx_valid/tx_data/tx_ready : FWFT byte stream out of the transmit FIFO
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   r_ram [DEPTH_WORDS];
  logic [31:0]   r_cycle;
  logic          w_is_mmio;
  mmio_reg_e     w_reg;
  logic [AW-1:0] w_ram_idx;
  logic          w_cyc_wr;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_is_mmio = aluout[MMIO_SEL_BIT];
  assign w_reg     = mmio_decode(aluout[31:2]);
  assign w_ram_idx = aluout[AW+1:2];
  assign w_cyc_wr  = memwrite && w_is_mmio && (w_reg == MMIO_CYCLE);

  always_ff @(posedge clk) begin
    if (memwrite && !w_is_mmio) r_ram[w_ram_idx] <= writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_cycle <= '0;
    else if (w_cyc_wr) r_cycle <= writedata;
    else               r_cycle <= r_cycle + 1'b1;
  end

`ifdef DMEM_TXFIFO_EN
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          r_ovf;
  logic          w_push_req;
  logic          w_pop;
  logic          w_drop;
  logic          w_ovf_clr;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic [7:0]    w_head;

  assign w_push_req = memwrite && w_is_mmio && (w_reg == MMIO_TXDATA);
  assign w_pop      = !w_empty && tx_ready;
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = memwrite && w_is_mmio && (w_reg == MMIO_STATUS) && writedata[ST_OVF];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_txfifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push_req),
    .pop   (w_pop),
    .wdata (writedata[7:0]),
    .rdata (w_head),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  // A drop in the same cycle as a clear leaves ovf set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  always_comb begin
    w_status                     = '0;
    w_status[ST_CNT_LSB +: 8]    = 8'(w_count);
    w_status[ST_OVF]             = r_ovf;
    w_status[ST_FULL]            = w_full;
    w_status[ST_EMPTY]           = w_empty;
  end

  assign tx_valid = !w_empty;
  assign tx_data  = w_head;
  assign w_unused = &{1'b0, aluout[1:0]};
`else
  assign w_status = '0;
  assign tx_valid = 1'b0;
  assign tx_data  = '0;
  assign w_unused = &{1'b0, aluout[1:0], tx_ready};
`endif

  always_comb begin
    readdata = '0;
    if (!w_is_mmio) begin
      readdata = r_ram[w_ram_idx];
    end else begin
      case (w_reg)
        MMIO_CYCLE:  readdata = r_cycle;
        MMIO_STATUS: readdata = w_status;
        default:     readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

`ifdef DMEM_TXFIFO_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam int FD    = 8;
  localparam int WORDS = 64;

  localparam logic [31:0] A_CYC = 32'h8000_0000;
  localparam logic [31:0] A_TX  = 32'h8000_0004;
  localparam logic [31:0] A_ST  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural reference state
  logic [31:0] m_ram  [WORDS];
  bit          m_ramv [WORDS];
  logic [31:0] m_cycle;
  logic [7:0]  m_q [$];
  bit          m_ovf;

  dmem_responder #(
    .DEPTH_WORDS(64),
    .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  function automatic bit is_reg(input logic [31:0] a, input logic [31:0] base);
    return (a & 32'hFFFF_FFFC) == base;
  endfunction

  function automatic int ram_index(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'd0;
    if (FEAT) begin
      s = (32'(m_q.size()) << 8) | (32'(m_ovf) << 2)
        | (32'(m_q.size() == FD) << 1) | 32'(m_q.size() == 0);
    end
    return s;
  endfunction

  function automatic bit m_known(input logic [31:0] a);
    if (a < 32'h8000_0000) return m_ramv[ram_index(a)];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < 32'h8000_0000) return m_ram[ram_index(a)];
    if (is_reg(a, A_CYC)) return m_cycle;
    if (is_reg(a, A_ST))  return m_status();
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tx();
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() > 0});
    chk("tx_data", {24'd0, tx_data}, (m_q.size() > 0) ? {24'd0, m_q[0]} : 32'd0);
  endtask

  // One clock cycle: drive, check pre-edge outputs, advance model on the edge.
  task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    bit pop;
    bit push;
    int sz;
    memwrite  = we;
    aluout    = a;
    writedata = wd;
    tx_ready  = rdy;
    #1;
    if (m_known(a)) chk("readdata", readdata, m_read(a));
    chk_tx();
    @(posedge clk);
    sz   = m_q.size();
    pop  = FEAT && (sz > 0) && rdy;
    push = FEAT && we && is_reg(a, A_TX);
    if (pop) m_q.delete(0);
    if (push) begin
      if (sz < FD || pop) m_q.push_back(wd[7:0]);
      else                m_ovf = 1'b1;
    end else if (FEAT && we && is_reg(a, A_ST) && wd[2]) begin
      m_ovf = 1'b0;
    end
    if (we && is_reg(a, A_CYC)) m_cycle = wd;
    else                        m_cycle = m_cycle + 32'd1;
    if (we && a < 32'h8000_0000) begin
      m_ram[ram_index(a)]  = wd;
      m_ramv[ram_index(a)] = 1'b1;
    end
    #2;
  endtask

  // Combinational read check without advancing the clock.
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0;
    aluout   = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic do_reset();
    memwrite = 1'b0;
    tx_ready = 1'b0;
    reset    = 1'b0;
    #1;
    m_cycle = 32'd0;
    m_q.delete();
    m_ovf = 1'b0;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    memwrite  = 1'b0;
    aluout    = 32'd0;
    writedata = 32'd0;
    tx_ready  = 1'b0;
    reset     = 1'b1;
    m_cycle   = 32'd0;
    m_ovf     = 1'b0;
    foreach (m_ramv[i]) m_ramv[i] = 1'b0;
    @(posedge clk);
    #2;
    do_reset();

    // Counter and STATUS after reset release
    peek("cycle_0", A_CYC, 32'd0);
    cyc(1'b0, A_CYC, 32'd0, 1'b0);
    peek("cycle_1", A_CYC, 32'd1);
    peek("status_reset", A_ST, FEAT ? 32'h0000_0001 : 32'd0);

    // RAM write and aliasing
    cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    peek("ram_0x10", 32'h0000_0010, 32'hDEAD_BEEF);
    peek("ram_alias_0x110", 32'h0000_0110, 32'hDEAD_BEEF);

    // Counter load and wrap
    cyc(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
    peek("cycle_load", A_CYC, 32'hFFFF_FFFE);
    cyc(1'b0, A_CYC, 32'd0, 1'b0);
    peek("cycle_max", A_CYC, 32'hFFFF_FFFF);
    cyc(1'b0, A_CYC, 32'd0, 1'b0);
    peek("cycle_wrap", A_CYC, 32'd0);

    // Overfill: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) cyc(1'b1, A_TX, 32'h41 + 32'(i), 1'b0);
    peek("status_overfill", A_ST, FEAT ? 32'h0000_0806 : 32'd0);
    peek("txdata_read", A_TX, 32'd0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_order", {24'd0, tx_data}, FEAT ? 32'h41 + 32'(i) : 32'd0);
      cyc(1'b0, 32'h0000_0010, 32'd0, 1'b1);
    end
    peek("status_drained_ovf", A_ST, FEAT ? 32'h0000_0005 : 32'd0);
    cyc(1'b1, A_ST, 32'h0000_0004, 1'b1);
    peek("status_ovf_clear", A_ST, FEAT ? 32'h0000_0001 : 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) cyc(1'b1, A_TX, 32'h60 + 32'(i), 1'b0);
    cyc(1'b1, A_TX, 32'h55, 1'b1);
    peek("status_full_pushpop", A_ST, FEAT ? 32'h0000_0802 : 32'd0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("full_pushpop_order", {24'd0, tx_data},
          FEAT ? ((i < 7) ? 32'h61 + 32'(i) : 32'h55) : 32'd0);
      cyc(1'b0, A_ST, 32'd0, 1'b1);
    end

    // Reset mid-drain with 3 entries
    for (int i = 0; i < 4; i++) cyc(1'b1, A_TX, 32'h70 + 32'(i), 1'b0);
    cyc(1'b0, A_ST, 32'd0, 1'b1);
    peek("status_3_entries", A_ST, FEAT ? 32'h0000_0300 : 32'd0);
    tx_ready = 1'b1;
    do_reset();
    peek("status_after_rst", A_ST, FEAT ? 32'h0000_0001 : 32'd0);
    peek("cycle_after_rst", A_CYC, 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: a = $urandom & 32'h7FFF_FFFF;
        3:       a = A_CYC;
        4, 5, 6: a = A_TX;
        7:       a = A_ST;
        8:       a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
        default: a = 32'h8000_0000 + 32'($urandom_range(0, 15));
      endcase
      cyc(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 2) == 0));
    end
    peek("status_final", A_ST, m_status());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
